// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner.
//   phase_e    : slot phase (blank gap / digit lit)
//   CODE_*     : 4-bit digit codes understood by the downstream decoder
package seven_segment_scanner_pkg;

  typedef enum logic {
    PH_GAP = 1'b0,
    PH_ON  = 1'b1
  } phase_e;

  localparam logic [3:0] CODE_ZERO = 4'h0;

  // Non-numeric glyphs understood by the decoder.
  localparam logic [3:0] CODE_DASH = 4'hA;
  localparam logic [3:0] CODE_F    = 4'hB;
  localparam logic [3:0] CODE_C    = 4'hC;
  localparam logic [3:0] CODE_N    = 4'hD;
  localparam logic [3:0] CODE_D    = 4'hE;
  localparam logic [3:0] CODE_U    = 4'hF;

endpackage

// File: rtl/seven_segment_prescaler.sv
// Terminal-count counter 0..DIV-1 with synchronous clear.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear to 0 (takes priority over counting)
//   en_i   : count enable
//   cnt_o  : current count
//   wrap_o : high in the cycle the count sits at DIV-1 with en_i=1
module seven_segment_prescaler #(
  parameter  int unsigned DIV = 100000,
  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == W'(DIV - 1));
    cnt_d  = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (en_i)  cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode display scanner: feeds one digit code at a time to
// the segment decoder, with an all-off gap at the start of each digit slot.
// Frames are loaded into a shadow and only become active at a frame boundary
// (index wrap, or while disabled) so a frame is never shown half old/half new.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   enable_i   : 1 = scan, 0 = dark and held at digit 0 slot start
//   load_i     : strobe, capture digits_i/dp_i into the shadow
//   digits_i   : 4-bit codes, digit 0 in [3:0] (rightmost)
//   dp_i       : decimal points, 1 = lit
//   blank_lz_i : blank leading zero digits (digit 0 never blanked)
//   pending_o  : shadow holds a frame not yet displayed
//   bcd_o      : current digit code to decoder
//   dp_o       : decimal point to decoder, active-low
//   anode_o    : digit enables, active-low, at most one low
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_GAP   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  output logic                    pending_o,
  output logic [3:0]              bcd_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   anode_o
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc;
  logic          wrap;

  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] sh_dig_q, act_dig_q;
  logic [NUM_DIGITS-1:0]      sh_dp_q,  act_dp_q;
  logic                       pending_q, pending_d;
  logic                       boundary;

  logic [NUM_DIGITS-1:0] blank;
  phase_e                phase;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [3:0]            bcd_q,   bcd_d;
  logic                  dp_q,    dp_d;

  // Disabling holds the counter at 0 so re-enable starts in the gap.
  seven_segment_prescaler #(.DIV(REFRESH_DIV)) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!enable_i),
    .en_i   (enable_i),
    .cnt_o  (presc),
    .wrap_o (wrap)
  );

  always_comb begin
    idx_d = idx_q;
    if (!enable_i)  idx_d = '0;
    else if (wrap)  idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // A disabled display counts as a boundary so a pending frame is not stuck.
  assign boundary  = !enable_i || (wrap && (idx_q == IW'(NUM_DIGITS - 1)));
  // A load in a boundary cycle still leaves its new frame pending.
  assign pending_d = load_i ? 1'b1 : (boundary ? 1'b0 : pending_q);

  // Priority scan from the most significant digit: a digit is blanked while
  // every code from it upward is zero. Codes only; dp does not matter.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (act_dig_q[i] == CODE_ZERO);
      blank[i] = blank_lz_i && zero_run;
    end
  end

  assign phase = (int'(presc) >= int'(BLANK_GAP)) ? PH_ON : PH_GAP;

  // Outputs are registered from the current counter state, so they lag it by
  // one cycle; code and dp are valid throughout the gap.
  always_comb begin
    bcd_d   = act_dig_q[idx_q];
    dp_d    = ~act_dp_q[idx_q];
    anode_d = '1;
    if (enable_i && (phase == PH_ON) && !blank[idx_q]) anode_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      pending_q <= 1'b0;
      anode_q   <= '1;
      bcd_q     <= CODE_ZERO;
      dp_q      <= 1'b1;
    end else begin
      idx_q     <= idx_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      if (boundary && pending_q) begin
        act_dig_q <= sh_dig_q;
        act_dp_q  <= sh_dp_q;
      end
      if (load_i) begin
        sh_dig_q <= digits_i;
        sh_dp_q  <= dp_i;
      end
    end
  end

  assign pending_o = pending_q;
  assign anode_o   = anode_q;
  assign bcd_o     = bcd_q;
  assign dp_o      = dp_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int GAP = 1;
  localparam int FRAME = N * DIV;

  logic           clk = 1'b0;
  logic           rst, enable, load, blank_lz;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_in;
  logic           pending;
  logic [3:0]     bcd;
  logic           dp_out;
  logic [N-1:0]   anode;

  seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_GAP(GAP)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .load_i     (load),
    .digits_i   (digits),
    .dp_i       (dp_in),
    .blank_lz_i (blank_lz),
    .pending_o  (pending),
    .bcd_o      (bcd),
    .dp_o       (dp_out),
    .anode_o    (anode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: scan position in cycles since the start of the frame, plus
  // shadow/active frames as plain vectors.
  int             pos;
  logic [4*N-1:0] sh_dig, ac_dig;
  logic [N-1:0]   sh_dp, ac_dp;
  logic           m_pend;
  logic [N-1:0]   e_an;
  logic [3:0]     e_bcd;
  logic           e_dp;

  function automatic int top_nonzero(input logic [4*N-1:0] d);
    int h = 0;
    for (int i = 0; i < N; i++) if (d[4*i +: 4] != 4'h0) h = i;
    return h;
  endfunction

  task automatic model_edge();
    int slot = pos / DIV;
    int off  = pos % DIV;
    if (rst) begin
      e_an = '1; e_bcd = 4'h0; e_dp = 1'b1;
      pos = 0; sh_dig = '0; ac_dig = '0; sh_dp = '0; ac_dp = '0; m_pend = 1'b0;
    end else begin
      e_bcd = ac_dig[4*slot +: 4];
      e_dp  = ~ac_dp[slot];
      e_an  = '1;
      if (enable && off >= GAP && !(blank_lz && slot > top_nonzero(ac_dig)))
        e_an[slot] = 1'b0;
      if (!enable || pos == FRAME - 1) begin
        if (m_pend) begin ac_dig = sh_dig; ac_dp = sh_dp; end
        m_pend = 1'b0;
      end
      pos = enable ? (pos + 1) % FRAME : 0;
      if (load) begin sh_dig = digits; sh_dp = dp_in; m_pend = 1'b1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("anode",   32'(anode),   32'(e_an));
    chk("bcd",     32'(bcd),     32'(e_bcd));
    chk("dp",      32'(dp_out),  32'(e_dp));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic goto_pos(input int p);
    for (int k = 0; k < 4 * FRAME && pos != p; k++) step();
    if (pos != p) chk("goto_timeout", 32'(pos), 32'(p));
  endtask

  initial begin
    pos = 0; sh_dig = '0; ac_dig = '0; sh_dp = '0; ac_dp = '0; m_pend = 1'b0;
    rst = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
    digits = '0; dp_in = '0;
    run(2);
    rst = 1'b0; enable = 1'b1;
    run(2 * FRAME);

    // load mid-frame, applied at the wrap
    goto_pos(5);
    do_load(16'h1234, 4'b0010);
    run(2 * FRAME + 3);

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1000);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // two loads, second on the wrap edge
    goto_pos(3);
    do_load(16'hAAAA, 4'b0000);
    goto_pos(FRAME - 1);
    do_load(16'hCDEF, 4'b0101);
    run(2 * FRAME + 2);

    // disable during digit 2 ON with a load pending
    goto_pos(2 * DIV);
    do_load(16'h9876, 4'b1111);
    step();
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(FRAME);

    // reset mid-frame with a load pending
    goto_pos(6);
    do_load(16'h4321, 4'b0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2 * FRAME);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom % 25) != 0;
      load   = ($urandom % 7) == 0;
      rst    = ($urandom % 600) == 0;
      if (k % 97 == 0) blank_lz = $urandom % 2;
      for (int i = 0; i < N; i++)
        digits[4*i +: 4] = ($urandom % 2) ? 4'($urandom) : 4'h0;
      dp_in = 4'($urandom);
      step();
    end
    load = 1'b0; rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
